// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage MIPS core, placed beside the ID stage.
// It detects load-use hazards, taken branches resolved in ID, and HI/LO
// reads while the mul/div unit is busy. From these it drives the PC hold,
// IF/ID hold, IF/ID flush and ID/EX bubble controls, and it keeps a
// saturating count of stalled cycles.
module hazard_ctrl_unit #(
  parameter int REG_AW            = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int BRANCH_PENALTY    = 1,
  parameter int CNT_W             = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_use_hilo,
  input  logic              id_br_taken,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              md_busy,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_count
);

  // The cycle counter only has to hold the longest remaining sequence length.
  localparam int MAXC = (LOAD_STALL_CYCLES > BRANCH_PENALTY) ? LOAD_STALL_CYCLES : BRANCH_PENALTY;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] LD_INIT = CW'(LOAD_STALL_CYCLES - 1);
  localparam logic [CW-1:0] BR_INIT = CW'(BRANCH_PENALTY - 1);

  typedef enum logic [1:0] {
    IDLE,
    LD_STALL,
    BR_FLUSH
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q;
  logic            load_use;
  logic            md_hazard;
  logic            stall_set;
  logic            flush_set;

  // Register $0 is hard-wired to zero, so a load that targets it never creates a hazard.
  assign load_use = id_valid & ex_mem_read & (ex_rd != '0) &
                    ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
  assign md_hazard = id_valid & id_use_hilo & md_busy;

  // State and cycle-counter registers. Reset immediately abandons any stall or flush in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and Mealy controls. In IDLE the priority is load-use, then mul/div, then branch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_set = 1'b0;
    flush_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_use) begin
          stall_set = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = LD_STALL;
            cnt_d   = LD_INIT;
          end
        end else if (md_hazard) begin
          stall_set = 1'b1;
        end else if (id_valid && id_br_taken) begin
          flush_set = 1'b1;
          if (BRANCH_PENALTY > 1) begin
            state_d = BR_FLUSH;
            cnt_d   = BR_INIT;
          end
        end
      end
      LD_STALL: begin
        stall_set = 1'b1;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = IDLE;
      end
      BR_FLUSH: begin
        flush_set = 1'b1;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Performance counter of stalled cycles. It sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
    end else if (pc_stall && (stall_count_q != '1)) begin
      stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  // The outputs are forced low while reset is held, even if the ID inputs still show a hazard.
  assign pc_stall    = stall_set & ~rst;
  assign ifid_stall  = stall_set & ~rst;
  assign idex_bubble = stall_set & ~rst;
  assign ifid_flush  = flush_set & ~rst;
  assign busy        = (state_q != IDLE) & ~rst;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit. Two instances share the same stimulus: one
// uses the default parameters, and the other uses a 3-cycle load stall, a
// 2-cycle branch flush and a 4-bit counter. The driver pushes the
// hand-computed expectations for each cycle into a queue. The monitor pops
// and compares them on the falling edge.
module tb_hazard_ctrl_unit;

  localparam int NONE = 'b00000;
  localparam int STL  = 'b11010;
  localparam int STLB = 'b11011;
  localparam int FL   = 'b00100;
  localparam int FLB  = 'b00101;

  typedef struct {
    int         id;
    logic [4:0] flagsA;
    logic [15:0] cntA;
    logic [4:0] flagsB;
    logic [3:0] cntB;
  } exp_t;

  logic clk;
  logic rst;
  logic idValid, idUseRs, idUseRt, idUseHilo, idBrTaken, exMemRead, mdBusy;
  logic [4:0] idRs, idRt, exRd;

  logic pcA, ifsA, flA, bubA, busyA;
  logic [15:0] cntA;
  logic pcB, ifsB, flB, bubB, busyB;
  logic [3:0] cntB;

  exp_t expQ[$];
  int compared = 0;
  int mismatched = 0;
  int vecId = 0;

  hazard_ctrl_unit dutA (
    .clk(clk), .rst(rst), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
    .id_use_rs(idUseRs), .id_use_rt(idUseRt), .id_use_hilo(idUseHilo),
    .id_br_taken(idBrTaken), .ex_mem_read(exMemRead), .ex_rd(exRd), .md_busy(mdBusy),
    .pc_stall(pcA), .ifid_stall(ifsA), .ifid_flush(flA), .idex_bubble(bubA),
    .busy(busyA), .stall_count(cntA)
  );

  hazard_ctrl_unit #(
    .REG_AW(5), .LOAD_STALL_CYCLES(3), .BRANCH_PENALTY(2), .CNT_W(4)
  ) dutB (
    .clk(clk), .rst(rst), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
    .id_use_rs(idUseRs), .id_use_rt(idUseRt), .id_use_hilo(idUseHilo),
    .id_br_taken(idBrTaken), .ex_mem_read(exMemRead), .ex_rd(exRd), .md_busy(mdBusy),
    .pc_stall(pcB), .ifid_stall(ifsB), .ifid_flush(flB), .idex_bubble(bubB),
    .busy(busyB), .stall_count(cntB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge, then queue what both instances should show.
  task automatic applyStimulus(input int r, input int v, input int rs, input int rt,
                               input int urs, input int urt, input int uh, input int br,
                               input int mr, input int exrd, input int mdb,
                               input int fa, input int ca, input int fb, input int cb);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r[0];
    idValid   = v[0];
    idRs      = 5'(rs);
    idRt      = 5'(rt);
    idUseRs   = urs[0];
    idUseRt   = urt[0];
    idUseHilo = uh[0];
    idBrTaken = br[0];
    exMemRead = mr[0];
    exRd      = 5'(exrd);
    mdBusy    = mdb[0];
    e.id      = vecId;
    e.flagsA  = 5'(fa);
    e.cntA    = 16'(ca);
    e.flagsB  = 5'(fb);
    e.cntB    = 4'(cb);
    expQ.push_back(e);
    vecId++;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [4:0] gotA, gotB;
    gotA = {pcA, ifsA, flA, bubA, busyA};
    gotB = {pcB, ifsB, flB, bubB, busyB};
    compared++;
    if (gotA !== e.flagsA) begin
      mismatched++;
      $display("[TB] FAIL flagsA vec%0d got %b expected %b", e.id, gotA, e.flagsA);
    end
    compared++;
    if (cntA !== e.cntA) begin
      mismatched++;
      $display("[TB] FAIL countA vec%0d got %0d expected %0d", e.id, cntA, e.cntA);
    end
    compared++;
    if (gotB !== e.flagsB) begin
      mismatched++;
      $display("[TB] FAIL flagsB vec%0d got %b expected %b", e.id, gotB, e.flagsB);
    end
    compared++;
    if (cntB !== e.cntB) begin
      mismatched++;
      $display("[TB] FAIL countB vec%0d got %0d expected %0d", e.id, cntB, e.cntB);
    end
  endtask

  // Monitor: the Mealy outputs settle mid-cycle, so the queued expectation is checked on the falling edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  task automatic pulseReset();
    applyStimulus(1,0,0,0,0,0,0,0,0,0,0, NONE,0, NONE,0);
  endtask

  task automatic quietCycle(input int ca, input int fb, input int cb);
    applyStimulus(0,0,0,0,0,0,0,0,0,0,0, NONE,ca, fb,cb);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    idValid = 0; idUseRs = 0; idUseRt = 0; idUseHilo = 0;
    idBrTaken = 0; exMemRead = 0; mdBusy = 0;
    idRs = '0; idRt = '0; exRd = '0;
    repeat (2) @(posedge clk);

    $display("[TB] reset state");
    pulseReset();

    $display("[TB] load-use: 1 stall on A, 3 stalls on B");
    applyStimulus(0,1,8,0,1,0,0,0,1,8,0, STL,0, STL,0);
    applyStimulus(0,1,8,0,1,0,0,0,0,8,0, NONE,1, STLB,1);
    applyStimulus(0,1,8,0,1,0,0,0,0,8,0, NONE,1, STLB,2);
    applyStimulus(0,1,8,0,1,0,0,0,0,8,0, NONE,1, NONE,3);
    pulseReset();

    $display("[TB] taken branch, load-use during flush");
    applyStimulus(0,1,0,0,0,0,0,1,0,0,0, FL,0, FL,0);
    applyStimulus(0,1,8,0,1,0,0,0,1,8,0, STL,0, FLB,0);
    quietCycle(1, NONE, 0);
    pulseReset();

    $display("[TB] load-use together with taken branch");
    applyStimulus(0,1,8,0,1,0,0,1,1,8,0, STL,0, STL,0);
    applyStimulus(0,1,8,0,1,0,0,1,0,8,0, FL,1, STLB,1);
    applyStimulus(0,1,8,0,1,0,0,1,0,8,0, FL,1, STLB,2);
    applyStimulus(0,1,8,0,1,0,0,1,0,8,0, FL,1, FL,3);
    quietCycle(1, FLB, 3);
    quietCycle(1, NONE, 3);
    pulseReset();

    $display("[TB] no-hazard cases and rt hazard");
    applyStimulus(0,1,0,0,1,0,0,0,1,0,0, NONE,0, NONE,0);
    applyStimulus(0,1,3,9,0,0,0,0,1,9,0, NONE,0, NONE,0);
    applyStimulus(0,0,9,0,1,0,0,0,1,9,0, NONE,0, NONE,0);
    applyStimulus(0,1,3,9,0,1,0,0,1,9,0, STL,0, STL,0);
    quietCycle(1, STLB, 1);
    quietCycle(1, STLB, 2);
    quietCycle(1, NONE, 3);
    pulseReset();

    $display("[TB] mul/div busy with HI/LO read and pending branch");
    applyStimulus(0,1,0,0,0,0,0,0,0,0,1, NONE,0, NONE,0);
    for (int k = 0; k < 4; k++)
      applyStimulus(0,1,0,0,0,0,1,1,0,0,1, STL,k, STL,k);
    applyStimulus(0,1,0,0,0,0,1,1,0,0,0, FL,4, FL,4);
    quietCycle(4, FLB, 4);
    quietCycle(4, NONE, 4);
    pulseReset();

    $display("[TB] counter saturation and reset abort");
    for (int k = 0; k < 20; k++)
      applyStimulus(0,1,0,0,0,0,1,0,0,0,1, STL,k, STL,(k > 15) ? 15 : k);
    quietCycle(20, NONE, 15);
    applyStimulus(0,1,8,0,1,0,0,0,1,8,0, STL,20, STL,15);
    quietCycle(21, STLB, 15);
    applyStimulus(1,1,8,0,1,0,0,0,1,8,0, NONE,0, NONE,0);
    quietCycle(0, NONE, 0);
    applyStimulus(0,1,0,0,0,0,0,1,0,0,0, FL,0, FL,0);
    pulseReset();
    quietCycle(0, NONE, 0);

    guard = 0;
    while (expQ.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (expQ.size() > 0) begin
      mismatched++;
      $display("[TB] FAIL drain %0d expectations left unchecked, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
